// File: rtl/lsu_rv32i.sv
// MEM-stage load/store unit: address generation, legality checks, single-cycle memory access, registered response.
// Optional build macro LSU_MISALIGN_TRAP_EN enables trapping of misaligned accesses (exc 01).
module lsu_rv32i #(
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned XLEN   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_is_store,
    input  logic [2:0]        req_funct3,
    input  logic [XLEN-1:0]   req_base,
    input  logic [11:0]       req_imm,
    input  logic [XLEN-1:0]   req_wdata,
    input  logic [4:0]        req_rd,
    output logic              mem_we,
    output logic              mem_re,
    output logic [2:0]        mem_width_sel,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [XLEN-1:0]   mem_wdata,
    input  logic [XLEN-1:0]   mem_rdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [XLEN-1:0]   resp_rdata,
    output logic [4:0]        resp_rd,
    output logic              resp_is_load,
    output logic [1:0]        resp_exc
);

    localparam int unsigned IMM_W = 12;

    localparam logic [1:0] EXC_OK       = 2'b00;
    localparam logic [1:0] EXC_MISALIGN = 2'b01;
    localparam logic [1:0] EXC_FAULT    = 2'b10;
    localparam logic [1:0] EXC_ILLEGAL  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [XLEN-1:0] ea_c;
    logic            illegal_c;
    logic            fault_c;
    logic [1:0]      exc_c;
    logic [2:0]      width_c;

    logic              ready_d, we_d, re_d, rvalid_d, is_load_d;
    logic [2:0]        width_d;
    logic [ADDR_W-1:0] addr_d;
    logic [XLEN-1:0]   wdata_d, rdata_d;
    logic [4:0]        rd_d;
    logic [1:0]        exc_d;

    // Effective address with sign-extended 12-bit offset, wrapping at XLEN bits
    assign ea_c = req_base + {{(XLEN-IMM_W){req_imm[IMM_W-1]}}, req_imm};

    assign illegal_c = req_is_store ? (req_funct3 > 3'b010)
                                    : ((req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11));
    assign fault_c   = |ea_c[XLEN-1:ADDR_W];

`ifdef LSU_MISALIGN_TRAP_EN
    logic misalign_c;
    assign misalign_c = ((req_funct3[1:0] == 2'b01) && ea_c[0]) ||
                        ((req_funct3[1:0] == 2'b10) && (ea_c[1:0] != 2'b00));
`endif

    // Only the highest-priority fault is reported: illegal > access fault > misaligned
    always_comb begin
        exc_c = EXC_OK;
`ifdef LSU_MISALIGN_TRAP_EN
        if (misalign_c) exc_c = EXC_MISALIGN;
`endif
        if (fault_c)   exc_c = EXC_FAULT;
        if (illegal_c) exc_c = EXC_ILLEGAL;
    end

    // RV32I funct3 to memory width_sel; the unsigned loads get their own codes
    always_comb begin
        width_c = 3'b000;
        case (req_funct3)
            3'b000:  width_c = 3'b000;
            3'b001:  width_c = 3'b001;
            3'b010:  width_c = 3'b010;
            3'b100:  width_c = 3'b011;
            3'b101:  width_c = 3'b100;
            default: width_c = 3'b000;
        endcase
    end

    // Next-state and next-output logic
    always_comb begin
        state_d   = state_q;
        ready_d   = 1'b0;
        we_d      = 1'b0;
        re_d      = 1'b0;
        addr_d    = mem_addr;
        width_d   = mem_width_sel;
        wdata_d   = mem_wdata;
        rvalid_d  = resp_valid;
        rdata_d   = resp_rdata;
        rd_d      = resp_rd;
        is_load_d = resp_is_load;
        exc_d     = resp_exc;

        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    rd_d      = req_rd;
                    is_load_d = !req_is_store;
                    rdata_d   = '0;
                    exc_d     = exc_c;
                    if (exc_c != EXC_OK) begin
                        rvalid_d = 1'b1;
                        state_d  = S_RESP;
                    end else begin
                        addr_d  = ea_c[ADDR_W-1:0];
                        width_d = width_c;
                        wdata_d = req_wdata;
                        we_d    = req_is_store;
                        re_d    = !req_is_store;
                        state_d = S_ISSUE;
                    end
                end else begin
                    ready_d = 1'b1;
                end
            end
            S_ISSUE: begin
                rvalid_d = !resp_is_load;
                state_d  = resp_is_load ? S_WAIT : S_RESP;
            end
            S_WAIT: begin
                rdata_d  = mem_rdata;
                rvalid_d = 1'b1;
                state_d  = S_RESP;
            end
            S_RESP: begin
                if (resp_ready) begin
                    rvalid_d = 1'b0;
                    ready_d  = 1'b1;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                ready_d  = 1'b1;
                rvalid_d = 1'b0;
                state_d  = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops any in-flight access or pending response
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            req_ready     <= 1'b1;
            mem_we        <= 1'b0;
            mem_re        <= 1'b0;
            mem_width_sel <= '0;
            mem_addr      <= '0;
            mem_wdata     <= '0;
            resp_valid    <= 1'b0;
            resp_rdata    <= '0;
            resp_rd       <= '0;
            resp_is_load  <= 1'b0;
            resp_exc      <= EXC_OK;
        end else begin
            state_q       <= state_d;
            req_ready     <= ready_d;
            mem_we        <= we_d;
            mem_re        <= re_d;
            mem_width_sel <= width_d;
            mem_addr      <= addr_d;
            mem_wdata     <= wdata_d;
            resp_valid    <= rvalid_d;
            resp_rdata    <= rdata_d;
            resp_rd       <= rd_d;
            resp_is_load  <= is_load_d;
            resp_exc      <= exc_d;
        end
    end

endmodule

// File: tb/tb_lsu_rv32i.sv
// Self-checking bench for lsu_rv32i: behavioural data memory, byte-array reference model, directed and random requests.
module tb_lsu_rv32i;

`ifdef LSU_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_is_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_base, req_wdata;
    logic [11:0] req_imm;
    logic [4:0]  req_rd;
    logic        mem_we, mem_re;
    logic [2:0]  mem_width_sel;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wdata, mem_rdata;
    logic        resp_valid, resp_ready, resp_is_load;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic [1:0]  resp_exc;

    int n_checks = 0;
    int n_pass   = 0;

    lsu_rv32i #(.ADDR_W(9), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
        .req_funct3(req_funct3), .req_base(req_base), .req_imm(req_imm),
        .req_wdata(req_wdata), .req_rd(req_rd),
        .mem_we(mem_we), .mem_re(mem_re), .mem_width_sel(mem_width_sel),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_rd(resp_rd), .resp_is_load(resp_is_load), .resp_exc(resp_exc)
    );

    always #5 clk = ~clk;

    // Behavioural data memory: synchronous read, lane placement, extension, zero-on-misalign
    logic [7:0] dev_mem  [512];
    logic [7:0] seed_img [512];
    logic [7:0] ref_mem  [512];
    logic       seed;

    function automatic logic [31:0] dev_read(input logic [8:0] a, input logic [2:0] w);
        logic [7:0] b0, b1, b2, b3;
        b0 = dev_mem[a];
        b1 = dev_mem[9'(a + 9'd1)];
        b2 = dev_mem[9'(a + 9'd2)];
        b3 = dev_mem[9'(a + 9'd3)];
        case (w)
            3'b000:  return {{24{b0[7]}}, b0};
            3'b011:  return {24'b0, b0};
            3'b001:  return a[0] ? 32'b0 : {{16{b1[7]}}, b1, b0};
            3'b100:  return a[0] ? 32'b0 : {16'b0, b1, b0};
            3'b010:  return (a[1:0] != 2'b00) ? 32'b0 : {b3, b2, b1, b0};
            default: return 32'b0;
        endcase
    endfunction

    always @(posedge clk) begin
        if (seed) begin
            for (int i = 0; i < 512; i++) dev_mem[i] <= seed_img[i];
        end else if (mem_we) begin
            case (mem_width_sel)
                3'b000: dev_mem[mem_addr] <= mem_wdata[7:0];
                3'b001: if (!mem_addr[0]) begin
                    dev_mem[mem_addr]            <= mem_wdata[7:0];
                    dev_mem[9'(mem_addr + 9'd1)] <= mem_wdata[15:8];
                end
                3'b010: if (mem_addr[1:0] == 2'b00) begin
                    dev_mem[mem_addr]            <= mem_wdata[7:0];
                    dev_mem[9'(mem_addr + 9'd1)] <= mem_wdata[15:8];
                    dev_mem[9'(mem_addr + 9'd2)] <= mem_wdata[23:16];
                    dev_mem[9'(mem_addr + 9'd3)] <= mem_wdata[31:24];
                end
                default: ;
            endcase
        end
        if (mem_re) mem_rdata <= dev_read(mem_addr, mem_width_sel);
    end

    // Strobe monitor, sampled on the falling edge
    int we_cnt = 0, re_cnt = 0, both_cnt = 0;
    logic [8:0]  s_addr;
    logic [2:0]  s_width;
    logic [31:0] s_wdata;
    always @(negedge clk) begin
        if (mem_we || mem_re) begin
            s_addr  = mem_addr;
            s_width = mem_width_sel;
            s_wdata = mem_wdata;
        end
        if (mem_we) we_cnt++;
        if (mem_re) re_cnt++;
        if (mem_we && mem_re) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    // Reference model: architectural effect of one request on a byte-array memory
    task automatic ref_exec(input bit st, input int f3, input logic [31:0] base, input int imm,
                            input logic [31:0] wd, output logic [1:0] exc, output logic [31:0] rdata,
                            output logic [31:0] ea, output bit misal);
        longint simm, val;
        int     size;
        bit     legal;
        simm  = (imm >= 2048) ? longint'(imm - 4096) : longint'(imm);
        ea    = 32'((longint'(base) + simm) & 64'hFFFF_FFFF);
        size  = 1 << (f3 % 4);
        legal = st ? (f3 <= 2) : (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5);
        misal = (ea % size) != 0;
        rdata = 32'b0;
        if (!legal)             exc = 2'd3;
        else if (ea >= 512)     exc = 2'd2;
        else if (misal && TRAP) exc = 2'd1;
        else                    exc = 2'd0;
        if (exc == 2'd0 && !misal) begin
            if (st) begin
                for (int k = 0; k < size; k++) ref_mem[int'(ea) + k] = 8'(wd >> (8 * k));
            end else begin
                val = 0;
                for (int k = 0; k < size; k++) val = val | (longint'(ref_mem[int'(ea) + k]) << (8 * k));
                if (f3 < 4 && size < 4 && val[8*size-1]) val = val - (longint'(1) << (8 * size));
                rdata = 32'(val);
            end
        end
    endtask

    // One request through accept, response, optional back-pressure and handshake
    task automatic do_req(input bit st, input int f3, input logic [31:0] base, input int imm,
                          input logic [31:0] wd, input int hold);
        logic [1:0]  e_exc;
        logic [31:0] e_rdata, e_ea;
        bit          misal;
        logic [4:0]  tag;
        int          lat, exp_lat, we0, re0, e_strobe;
        tag = 5'($urandom);
        ref_exec(st, f3, base, imm, wd, e_exc, e_rdata, e_ea, misal);
        check("idle_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1; req_is_store = st; req_funct3 = 3'(f3); req_base = base;
        req_imm = 12'(imm); req_wdata = wd; req_rd = tag; resp_ready = (hold == 0);
        we0 = we_cnt; re0 = re_cnt;
        @(posedge clk); #1;
        req_valid = 1'b0; req_base = $urandom; req_funct3 = 3'($urandom);
        req_is_store = 1'($urandom); req_wdata = $urandom; req_rd = 5'($urandom); req_imm = 12'($urandom);
        lat = 1;
        while (resp_valid !== 1'b1 && lat < 8) begin
            @(posedge clk); #1;
            lat++;
        end
        exp_lat = (e_exc != 2'd0) ? 1 : (st ? 2 : 3);
        check("latency", 32'(lat), 32'(exp_lat));
        check("resp_exc", 32'(resp_exc), 32'(e_exc));
        check("resp_rdata", resp_rdata, e_rdata);
        check("resp_rd", 32'(resp_rd), 32'(tag));
        check("resp_is_load", 32'(resp_is_load), 32'(!st));
        check("busy_ready", 32'(req_ready), 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check("hold_valid", 32'(resp_valid), 32'd1);
            check("hold_rdata", resp_rdata, e_rdata);
            check("hold_exc", 32'(resp_exc), 32'(e_exc));
            check("hold_ready", 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        check("post_valid", 32'(resp_valid), 32'd0);
        check("post_ready", 32'(req_ready), 32'd1);
        resp_ready = 1'b0;
        e_strobe = (e_exc == 2'd0) ? 1 : 0;
        check("we_pulses", 32'(we_cnt - we0), st ? 32'(e_strobe) : 32'd0);
        check("re_pulses", 32'(re_cnt - re0), st ? 32'd0 : 32'(e_strobe));
        if (e_strobe == 1) begin
            check("strobe_addr", 32'(s_addr), 32'(e_ea[8:0]));
            check("strobe_width", 32'(s_width), (f3 == 4) ? 32'd3 : (f3 == 5) ? 32'd4 : 32'(f3));
            if (st) check("strobe_wdata", s_wdata, wd);
        end
    endtask

    initial begin
        int any_resp;
        for (int i = 0; i < 512; i++) begin
            seed_img[i] = 8'($urandom);
            ref_mem[i]  = seed_img[i];
        end
        rst = 1'b1; seed = 1'b1;
        req_valid = 1'b0; req_is_store = 1'b0; req_funct3 = 3'b0; req_base = 32'b0;
        req_imm = 12'b0; req_wdata = 32'b0; req_rd = 5'b0; resp_ready = 1'b0;
        @(posedge clk); #1;
        seed = 1'b0;
        @(posedge clk); #1;
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_resp_valid", 32'(resp_valid), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_mem_re", 32'(mem_re), 32'd0);
        check("rst_resp_rdata", resp_rdata, 32'd0);
        rst = 1'b0;

        // Directed: store/load, width translation, exceptions, wrap, priority, back-pressure
        do_req(1'b1, 2, 32'h10, 12'hFF0, 32'hA5A5_0000, 0);
        do_req(1'b0, 2, 32'h0, 0, 32'h0, 0);
        do_req(1'b0, 4, 32'h3, 0, 32'h0, 0);
        do_req(1'b0, 5, 32'h2, 0, 32'h0, 0);
        do_req(1'b1, 0, 32'h15, 0, 32'h0000_0022, 0);
        do_req(1'b0, 0, 32'h15, 0, 32'h0, 0);
        do_req(1'b0, 2, 32'h2, 0, 32'h0, 0);
        do_req(1'b1, 1, 32'h41, 0, 32'h1234_5678, 0);
        do_req(1'b0, 1, 32'h41, 0, 32'h0, 0);
        do_req(1'b0, 2, 32'h200, 0, 32'h0, 0);
        do_req(1'b0, 7, 32'h0, 0, 32'h0, 0);
        do_req(1'b1, 3, 32'h201, 0, 32'h0, 0);
        do_req(1'b0, 2, 32'hFFFF_FFFF, 1, 32'h0, 0);
        do_req(1'b0, 0, 32'h0, 12'hFFF, 32'h0, 0);
        do_req(1'b0, 2, 32'h0, 0, 32'h0, 5);

        // Reset during WAIT: the pending load must never respond
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010; req_base = 32'h8;
        req_imm = 12'h0; req_rd = 5'd9; resp_ready = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst_req_ready", 32'(req_ready), 32'd1);
        check("midrst_resp_valid", 32'(resp_valid), 32'd0);
        check("midrst_mem_re", 32'(mem_re), 32'd0);
        check("midrst_mem_addr", 32'(mem_addr), 32'd0);
        any_resp = 0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (resp_valid === 1'b1) any_resp++;
        end
        check("midrst_no_resp", 32'(any_resp), 32'd0);
        resp_ready = 1'b0;

        // Random traffic against the reference model
        for (int n = 0; n < 80; n++) begin
            bit          st;
            int          f3, imm, hold;
            logic [31:0] base;
            st   = 1'($urandom);
            f3   = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 7) : $urandom_range(0, 2) + (st ? 0 : 4 * $urandom_range(0, 1));
            base = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, 520));
            imm  = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 15) : 4096 - $urandom_range(1, 16);
            hold = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 3) : 0;
            if (f3 == 6 && st == 1'b0 && $urandom_range(0, 1) == 1) f3 = 5;
            do_req(st, f3, base, imm, $urandom, hold);
        end

        check("strobes_exclusive", 32'(both_cnt), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
